// File: rtl/vx_csr_pending_tracker.sv
// Per-warp in-flight instruction tracker between issue and the CSR unit.
// Counts issued-but-uncommitted instructions per warp, answers alm_empty and holds FPU-CSR locks.
module vx_csr_pending_tracker #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_COMMITS = 2,
    parameter int CTR_WIDTH   = 6,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_fire,
    input  logic [NW_WIDTH-1:0]             issue_wid,
    input  logic                            issue_sop,
    input  logic                            issue_lock,
    input  logic [NUM_COMMITS-1:0]          commit_fire,
    input  logic [NUM_COMMITS*NW_WIDTH-1:0] commit_wid,
    input  logic [NUM_COMMITS-1:0]          commit_eop,
    input  logic [NW_WIDTH-1:0]             alm_empty_wid,
    output logic                            alm_empty,
    input  logic                            unlock_warp,
    input  logic [NW_WIDTH-1:0]             unlock_wid,
    output logic [NUM_WARPS-1:0]            warp_locked,
    output logic [NUM_WARPS-1:0]            warp_empty,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int DEC_WIDTH = (NUM_COMMITS > 0) ? $clog2(NUM_COMMITS + 1) : 1;
    localparam int SUM_WIDTH = CTR_WIDTH + 2;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

    typedef struct packed {
        logic                 ovf;
        logic                 unf;
        logic [CTR_WIDTH-1:0] val;
    } sat_result_t;

    // Net one cycle of increments/decrements, clamping into [0, CTR_MAX].
    function automatic sat_result_t sat_step(
        input logic [CTR_WIDTH-1:0] cur,
        input logic                 inc,
        input logic [DEC_WIDTH-1:0] dec
    );
        sat_result_t          res;
        logic [SUM_WIDTH-1:0] up;
        logic [SUM_WIDTH-1:0] down;
        logic [SUM_WIDTH-1:0] diff;
        up   = SUM_WIDTH'(cur) + SUM_WIDTH'(inc);
        down = SUM_WIDTH'(dec);
        diff = up - down;
        res  = '0;
        if (down > up) begin
            res.unf = 1'b1;
            res.val = {CTR_WIDTH{1'b0}};
        end else if (diff > SUM_WIDTH'(CTR_MAX)) begin
            res.ovf = 1'b1;
            res.val = CTR_MAX;
        end else begin
            res.val = CTR_WIDTH'(diff);
        end
        return res;
    endfunction

    logic [CTR_WIDTH-1:0] count_q [NUM_WARPS];
    logic [CTR_WIDTH-1:0] count_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] warp_locked_q, warp_locked_d;
    logic [NUM_WARPS-1:0] warp_empty_q, warp_empty_d;
    logic                 overflow_err_q, overflow_err_d;
    logic                 underflow_err_q, underflow_err_d;

    logic [NUM_WARPS-1:0] inc_s;
    logic [DEC_WIDTH-1:0] dec_s [NUM_WARPS];
    logic [NUM_WARPS-1:0] lock_set_s, lock_clr_s;
    logic                 alm_empty_s;

    // Per-warp issue/commit decode and lock set/clear masks.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_s[w]      = issue_fire & issue_sop & (issue_wid == NW_WIDTH'(w));
            lock_set_s[w] = issue_fire & issue_lock & (issue_wid == NW_WIDTH'(w));
            lock_clr_s[w] = unlock_warp & (unlock_wid == NW_WIDTH'(w));
            dec_s[w]      = {DEC_WIDTH{1'b0}};
            for (int p = 0; p < NUM_COMMITS; p++) begin
                dec_s[w] = dec_s[w] + DEC_WIDTH'(commit_fire[p] & commit_eop[p]
                           & (commit_wid[p*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)));
            end
        end
    end

    // Next-state for counters, empty mask, lock mask and sticky error flags.
    always_comb begin
        sat_result_t res;
        res             = '0;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            res             = sat_step(count_q[w], inc_s[w], dec_s[w]);
            count_d[w]      = res.val;
            warp_empty_d[w] = (res.val == {CTR_WIDTH{1'b0}});
            overflow_err_d  = overflow_err_d | res.ovf;
            underflow_err_d = underflow_err_d | res.unf;
        end
        // A lock issued in the same cycle as an unlock belongs to a newer instruction.
        warp_locked_d = lock_set_s | (warp_locked_q & ~lock_clr_s);
    end

    // alm_empty looks at registered counts; a query outside the warp range matches nothing.
    always_comb begin
        alm_empty_s = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            alm_empty_s = alm_empty_s
                        | ((alm_empty_wid == NW_WIDTH'(w)) & (count_q[w] == CTR_WIDTH'(1)));
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= {CTR_WIDTH{1'b0}};
            end
            warp_locked_q   <= {NUM_WARPS{1'b0}};
            warp_empty_q    <= {NUM_WARPS{1'b1}};
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= count_d[w];
            end
            warp_locked_q   <= warp_locked_d;
            warp_empty_q    <= warp_empty_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign alm_empty     = alm_empty_s;
    assign warp_locked   = warp_locked_q;
    assign warp_empty    = warp_empty_q;
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_vx_csr_pending_tracker.sv
// Directed and random checks of vx_csr_pending_tracker against a per-warp integer model.
module tb_vx_csr_pending_tracker;

    localparam int NW  = 4;
    localparam int NC  = 2;
    localparam int MAX = 63;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_fire, issue_sop, issue_lock;
    logic [1:0]    issue_wid;
    logic [NC-1:0] commit_fire, commit_eop;
    logic [3:0]    commit_wid;
    logic [1:0]    alm_empty_wid;
    logic          alm_empty;
    logic          unlock_warp;
    logic [1:0]    unlock_wid;
    logic [NW-1:0] warp_locked, warp_empty;
    logic          overflow_err, underflow_err;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: plain integer counts per warp
    int m_cnt [NW];
    bit m_lock [NW];
    bit m_ovf, m_unf;

    vx_csr_pending_tracker dut (
        .clk(clk), .reset(reset),
        .issue_fire(issue_fire), .issue_wid(issue_wid), .issue_sop(issue_sop),
        .issue_lock(issue_lock),
        .commit_fire(commit_fire), .commit_wid(commit_wid), .commit_eop(commit_eop),
        .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
        .unlock_warp(unlock_warp), .unlock_wid(unlock_wid),
        .warp_locked(warp_locked), .warp_empty(warp_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_fire = 1'b0; issue_sop = 1'b0; issue_lock = 1'b0; issue_wid = 2'd0;
        commit_fire = 2'b00; commit_eop = 2'b00; commit_wid = 4'd0;
        unlock_warp = 1'b0; unlock_wid = 2'd0;
    endtask

    task automatic model_apply();
        int n;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin m_cnt[w] = 0; m_lock[w] = 1'b0; end
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                n = m_cnt[w];
                if (issue_fire && issue_sop && issue_wid == w) n = n + 1;
                for (int p = 0; p < NC; p++)
                    if (commit_fire[p] && commit_eop[p] && commit_wid[p*2 +: 2] == w) n = n - 1;
                if (n > MAX) begin n = MAX; m_ovf = 1'b1; end
                if (n < 0) begin n = 0; m_unf = 1'b1; end
                m_cnt[w] = n;
            end
            if (unlock_warp) m_lock[unlock_wid] = 1'b0;
            if (issue_fire && issue_lock) m_lock[issue_wid] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [NW-1:0] e_empty, e_lock;
        for (int w = 0; w < NW; w++) begin
            e_empty[w] = (m_cnt[w] == 0);
            e_lock[w]  = m_lock[w];
        end
        chk("warp_empty", warp_empty, e_empty);
        chk("warp_locked", warp_locked, e_lock);
        chk("alm_empty", alm_empty, (m_cnt[alm_empty_wid] == 1));
        chk("overflow_err", overflow_err, m_ovf);
        chk("underflow_err", underflow_err, m_unf);
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        alm_empty_wid = 2'd1;
        tick(); tick();

        // 1: idle after reset
        reset = 1'b0;
        tick(); tick();
        chk("t1_empty", warp_empty, 4'b1111);
        chk("t1_locked", warp_locked, 4'b0000);
        chk("t1_alm", alm_empty, 1'b0);

        // 2: three issues on warp 1, two commits later
        for (int i = 0; i < 3; i++) begin
            issue_fire = 1'b1; issue_sop = 1'b1; issue_wid = 2'd1;
            tick();
        end
        idle();
        chk("t2_notempty", warp_empty[1], 1'b0);
        tick(); tick();
        commit_fire = 2'b01; commit_eop = 2'b01; commit_wid = 4'b0001;
        tick();
        chk("t2_alm_early", alm_empty, 1'b0);
        tick();
        idle();
        chk("t2_alm", alm_empty, 1'b1);

        // 3: issue plus two commits on warp 2 in one cycle; sop=0 ignored
        alm_empty_wid = 2'd2;
        issue_fire = 1'b1; issue_sop = 1'b1; issue_wid = 2'd2;
        tick(); tick();
        commit_fire = 2'b11; commit_eop = 2'b11; commit_wid = 4'b1010;
        tick();
        chk("t3_alm_net", alm_empty, 1'b1);
        idle();
        issue_fire = 1'b1; issue_sop = 1'b0; issue_wid = 2'd2;
        tick();
        idle();
        chk("t3_nosop", alm_empty, 1'b1);

        // 4: lock, set-wins-over-clear, unlock
        issue_fire = 1'b1; issue_sop = 1'b1; issue_lock = 1'b1; issue_wid = 2'd3;
        tick();
        chk("t4_lock", warp_locked, 4'b1000);
        unlock_warp = 1'b1; unlock_wid = 2'd3;
        tick();
        chk("t4_setwins", warp_locked, 4'b1000);
        idle();
        unlock_warp = 1'b1; unlock_wid = 2'd3;
        tick();
        chk("t4_unlock", warp_locked, 4'b0000);
        idle();
        unlock_warp = 1'b1; unlock_wid = 2'd0;
        tick();
        idle();

        // 5: underflow on empty warp 0, then overflow
        alm_empty_wid = 2'd0;
        commit_fire = 2'b01; commit_eop = 2'b01; commit_wid = 4'b0000;
        tick();
        idle();
        chk("t5_unf", underflow_err, 1'b1);
        chk("t5_empty0", warp_empty[0], 1'b1);
        for (int i = 0; i < 63; i++) begin
            issue_fire = 1'b1; issue_sop = 1'b1; issue_wid = 2'd0;
            tick();
        end
        chk("t5_no_ovf", overflow_err, 1'b0);
        tick();
        idle();
        chk("t5_ovf", overflow_err, 1'b1);
        commit_fire = 2'b11; commit_eop = 2'b11; commit_wid = 4'b0000;
        tick();
        idle();

        // 6: reset with live state
        issue_fire = 1'b1; issue_sop = 1'b1; issue_lock = 1'b1; issue_wid = 2'd1;
        tick();
        idle();
        reset = 1'b1;
        issue_fire = 1'b1; issue_sop = 1'b1; issue_lock = 1'b1; issue_wid = 2'd2;
        tick();
        reset = 1'b0;
        idle();
        chk("t6_empty", warp_empty, 4'b1111);
        chk("t6_locked", warp_locked, 4'b0000);
        chk("t6_errs", {overflow_err, underflow_err}, 2'b00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            issue_fire    = $urandom_range(0, 1);
            issue_sop     = ($urandom_range(0, 9) < 7);
            issue_lock    = ($urandom_range(0, 7) == 0);
            issue_wid     = 2'($urandom_range(0, 3));
            commit_fire   = 2'($urandom_range(0, 3));
            commit_eop    = 2'($urandom_range(0, 3));
            commit_wid    = 4'($urandom_range(0, 15));
            unlock_warp   = ($urandom_range(0, 3) == 0);
            unlock_wid    = 2'($urandom_range(0, 3));
            alm_empty_wid = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
